regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of each register.
REQ-002 Parameter NUM_REGISTERS, default 32, SHALL set the register count; AW = $clog2(NUM_REGISTERS).
REQ-003 Parameter NUM_READ_PORTS, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL make register 0 hardwired to zero when 1.
REQ-005 Parameter PEND_W, default 2, SHALL set the per-register outstanding-write counter width; max count = 2**PEND_W-1.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  SHALL be the asynchronous, active-low reset (asserted at 0).
REQ-008 rd_addr  input  NUM_READ_PORTS x AW  SHALL give the read address per port.
REQ-009 rd_data  output  NUM_READ_PORTS x DATA_WIDTH  SHALL give the read data per port.
REQ-010 rd_busy  output  NUM_READ_PORTS  SHALL flag that the addressed register has an outstanding write.
REQ-011 wr_en / wr_addr / wr_data  input  1 / AW / DATA_WIDTH  SHALL form the writeback port.
REQ-012 issue_en / issue_addr  input  1 / AW  SHALL mark a destination register as pending one more write.
REQ-013 issue_ready  output  1  SHALL be 1 when an issue to issue_addr is accepted this cycle.
REQ-014 flush  input  1  SHALL clear all pending counters synchronously.

Function
REQ-015 Reads SHALL be combinational, zero latency, all ports independent.
REQ-016 Write bypass: wr_en=1 and wr_addr==rd_addr[p] SHALL drive rd_data[p]=wr_data in the same cycle.
REQ-017 With ZERO_REG=1, reads of address 0 SHALL return 0, rd_busy 0; writes and issues to 0 SHALL be ignored; issue_ready=1 for address 0.
REQ-018 wr_en=1 SHALL store wr_data into registers[wr_addr] at the next rising edge.
REQ-019 Counter update per register r, per edge: issue accepted to r only -> +1; writeback to r only -> -1 if nonzero, else unchanged; both -> unchanged.
REQ-020 issue_ready SHALL be 0 when pending[issue_addr]==max and no same-cycle writeback to issue_addr; issue_en while not ready SHALL be dropped without state change.
REQ-021 Writeback to a register with count 0 SHALL still update data; counter SHALL not underflow.
REQ-022 rd_busy[p] SHALL be 1 iff pending[rd_addr[p]]!=0, except 0 when wr_en to the same address and count==1 (busy bypass).
REQ-023 flush=1 SHALL zero all counters at the edge, overriding same-cycle issue and writeback counter effects; the data write SHALL still occur.
REQ-024 Out-of-range addresses (NUM_REGISTERS not a power of 2) SHALL read 0, not busy; writes/issues SHALL be ignored.

Reset
REQ-025 rst=0 SHALL immediately clear all registers and counters, independent of clk.
REQ-026 During and after reset: rd_data=0 (absent bypass), rd_busy=0, issue_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard in-flight issues/writes of that cycle.

Structure
REQ-028 Package regfile_pkg SHALL hold default parameter constants and the pending-count typedef.
REQ-029 Sub-module regfile_pend_ctr (one saturating up/down counter with flush) SHALL be instantiated per register.

Verification
REQ-030 Reset, write 0xDEADBEEF to x5, next cycle read x5 on both ports -> 0xDEADBEEF, rd_busy=0.
REQ-031 Write 0x1234 to x7 while reading x7 same cycle -> rd_data=0x1234 that cycle; write 0xFFFF to x0 -> x0 reads 0.
REQ-032 Issue x3 three times (PEND_W=2) -> rd_busy=1, fourth issue sees issue_ready=0 and count stays 3; one writeback -> issue_ready=1.
REQ-033 Count x9=1, writeback x9 while reading x9 -> rd_busy=0 and bypassed data that cycle; simultaneous issue+writeback on x9 -> count unchanged.
REQ-034 Count x4=2, flush with concurrent write 0xAA to x4 -> next cycle rd_busy=0, data 0xAA.
REQ-035 Pending counts nonzero, assert rst=0 between edges -> outputs zero/not busy immediately, issue_ready=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_NUM_REGISTERS  = 32;
    localparam int DEF_NUM_READ_PORTS = 2;
    localparam int DEF_ZERO_REG       = 1;
    localparam int DEF_PEND_W         = 2;

    typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

    typedef enum logic [1:0] {
        CTR_HOLD = 2'd0,
        CTR_INC  = 2'd1,
        CTR_DEC  = 2'd2
    } ctr_op_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback, issue and flush signals of the scoreboarded register file.
interface regfile_sb_if #(
    parameter int DATA_WIDTH     = regfile_pkg::DEF_DATA_WIDTH,
    parameter int NUM_REGISTERS  = regfile_pkg::DEF_NUM_REGISTERS,
    parameter int NUM_READ_PORTS = regfile_pkg::DEF_NUM_READ_PORTS
);
    localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

    logic [NUM_READ_PORTS-1:0][AW-1:0]         rd_addr;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ_PORTS-1:0]                 rd_busy;
    logic                                      wr_en;
    logic [AW-1:0]                             wr_addr;
    logic [DATA_WIDTH-1:0]                     wr_data;
    logic                                      issue_en;
    logic [AW-1:0]                             issue_addr;
    logic                                      issue_ready;
    logic                                      flush;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        input  rd_data, rd_busy, issue_ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
        output rd_data, rd_busy, issue_ready
    );

endinterface

// File: rtl/regfile_pend_ctr.sv
// Saturating up/down outstanding-write counter for one register; flush wins.
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              at_max
);

    logic [PEND_W-1:0] count_q, count_d;
    ctr_op_e           op;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        op = CTR_HOLD;
        if (inc && !dec)
            op = CTR_INC;
        else if (dec && !inc)
            op = CTR_DEC;

        count_d = count_q;
        case (op)
            CTR_INC: if (count_q != '1) count_d = count_q + 1'b1;
            CTR_DEC: if (count_q != '0) count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush)
            count_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count  = count_q;
    assign at_max = (count_q == '1);

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write bypass and per-register pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_REGISTERS  = DEF_NUM_REGISTERS,
    parameter int NUM_READ_PORTS = DEF_NUM_READ_PORTS,
    parameter int ZERO_REG       = DEF_ZERO_REG,
    parameter int PEND_W         = DEF_PEND_W
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    localparam int AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGISTERS];
    logic [PEND_W-1:0]     cnt    [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] at_max, inc, dec;

    logic wr_ok, issue_ok, issue_ready;
    logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_READ_PORTS-1:0]                 rd_busy;

    // A "live" address is in range and not the hardwired zero register.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return (int'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        wr_ok       = bus.wr_en && addr_live(bus.wr_addr);
        issue_ready = 1'b1;
        if (addr_live(bus.issue_addr))
            issue_ready = !at_max[bus.issue_addr] ||
                          (wr_ok && (bus.wr_addr == bus.issue_addr));
        issue_ok    = bus.issue_en && addr_live(bus.issue_addr) && issue_ready;
    end

    for (genvar r = 0; r < NUM_REGISTERS; r++) begin : g_pend
        assign inc[r] = issue_ok && (bus.issue_addr == AW'(r));
        assign dec[r] = wr_ok && (bus.wr_addr == AW'(r));

        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk    (clk),
            .rst    (rst),
            .flush  (bus.flush),
            .inc    (inc[r]),
            .dec    (dec[r]),
            .count  (cnt[r]),
            .at_max (at_max[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[bus.wr_addr] = bus.wr_data;
    end

    // NOTE: the storage array is reset because a cleared register file is architecturally visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle writeback bypasses both data and the last outstanding busy flag.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            logic byp;
            byp        = 1'b0;
            rd_data[p] = '0;
            rd_busy[p] = 1'b0;
            if (addr_live(bus.rd_addr[p])) begin
                byp        = wr_ok && (bus.wr_addr == bus.rd_addr[p]);
                rd_data[p] = byp ? bus.wr_data : regs_q[bus.rd_addr[p]];
                rd_busy[p] = (cnt[bus.rd_addr[p]] != '0) &&
                             !(byp && (cnt[bus.rd_addr[p]] == PEND_W'(1)));
            end
        end
    end

    assign bus.rd_data     = rd_data;
    assign bus.rd_busy     = rd_busy;
    assign bus.issue_ready = issue_ready;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb: one table row per cycle plus a reset sequence.
module tb_regfile_sb;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    regfile_sb_if #(.DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_READ_PORTS(2)) bus ();

    regfile_sb #(
        .DATA_WIDTH(32), .NUM_REGISTERS(32), .NUM_READ_PORTS(2), .ZERO_REG(1), .PEND_W(2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;
        logic        b0, b1, rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ie,
                                logic [4:0] ia, logic fl, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] d0, logic [31:0] d1, logic b0, logic b1,
                                logic rdy);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic b0, input logic b1, input logic rdy);
        check($sformatf("%s rd_data0", tag), bus.rd_data[0], d0);
        check($sformatf("%s rd_data1", tag), bus.rd_data[1], d1);
        check($sformatf("%s rd_busy0", tag), 32'(bus.rd_busy[0]), 32'(b0));
        check($sformatf("%s rd_busy1", tag), 32'(bus.rd_busy[1]), 32'(b1));
        check($sformatf("%s issue_ready", tag), 32'(bus.issue_ready), 32'(rdy));
    endtask

    task automatic drive(input vec_t v);
        bus.wr_en      = v.we;
        bus.wr_addr    = v.wa;
        bus.wr_data    = v.wd;
        bus.issue_en   = v.ie;
        bus.issue_addr = v.ia;
        bus.flush      = v.fl;
        bus.rd_addr[0] = v.ra0;
        bus.rd_addr[1] = v.ra1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Writes/bypass to x5, x7, x0.
        vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 6, 32'hDEADBEEF, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(1, 7, 32'h1234, 0, 0, 0, 7, 5, 32'h1234, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'hFFFF, 0, 0, 0, 0, 7, 0, 32'h1234, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h1234, 0, 0, 1));
        // Fill x3 to saturation, then drain past zero.
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 3, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 3, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 3, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 3, 3, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 3, 32'h33, 0, 3, 0, 3, 3, 32'h33, 32'h33, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 3, 3, 32'h33, 32'h33, 1, 1, 1));
        vecs.push_back(mk(1, 3, 32'h34, 0, 3, 0, 3, 3, 32'h34, 32'h34, 1, 1, 1));
        vecs.push_back(mk(1, 3, 32'h35, 0, 3, 0, 3, 3, 32'h35, 32'h35, 0, 0, 1));
        vecs.push_back(mk(1, 3, 32'h36, 0, 3, 0, 3, 3, 32'h36, 32'h36, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 3, 0, 3, 3, 32'h36, 32'h36, 0, 0, 1));
        // x9: busy bypass, then simultaneous issue+writeback holds the count.
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 3, 0, 32'h36, 0, 1, 1));
        vecs.push_back(mk(1, 9, 32'h99, 0, 9, 0, 9, 9, 32'h99, 32'h99, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 9, 0, 9, 9, 32'h99, 32'h99, 0, 0, 1));
        vecs.push_back(mk(1, 9, 32'h9A, 1, 9, 0, 9, 9, 32'h9A, 32'h9A, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 9, 0, 9, 9, 32'h9A, 32'h9A, 1, 1, 1));
        vecs.push_back(mk(1, 9, 32'h9B, 0, 9, 0, 9, 9, 32'h9B, 32'h9B, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 9, 0, 9, 9, 32'h9B, 32'h9B, 0, 0, 1));
        // x4 flush with concurrent write; flush also drops an issue to x3.
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 4, 4, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 4, 0, 4, 4, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 4, 32'hAA, 1, 3, 1, 4, 3, 32'hAA, 32'h36, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 3, 0, 4, 3, 32'hAA, 32'h36, 0, 0, 1));
        // Issue to x0 is ignored.
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        // Saturate x12 ahead of the asynchronous reset.
        vecs.push_back(mk(0, 0, 0, 1, 12, 0, 12, 5, 0, 32'hDEADBEEF, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 12, 0, 12, 5, 0, 32'hDEADBEEF, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 12, 0, 12, 5, 0, 32'hDEADBEEF, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 12, 0, 12, 5, 0, 32'hDEADBEEF, 1, 0, 0));

        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 1));
        #12;
        check_outputs("reset", 0, 0, 0, 0, 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            check_outputs($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1,
                          vecs[i].b0, vecs[i].b1, vecs[i].rdy);
            @(posedge clk);
            #1;
        end

        // Reset between edges while an issue and a write are in flight.
        drive(mk(1, 6, 32'h66, 1, 12, 0, 12, 5, 0, 0, 0, 0, 0));
        #1 rst = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 0, 0, 1);
        @(posedge clk);
        #2;
        drive(mk(0, 0, 0, 0, 12, 0, 6, 12, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check_outputs("post_rst", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 12, 0, 6, 5, 0, 0, 0, 0, 0));
        #2;
        check_outputs("post_rst_cycle", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
